// File: rtl/byte_serial_adder_pkg.sv
// Shared constants and state encoding for the byte-serial adder.
// Optional build macro: BSA_SUB_EN (adds subtract mode).
package bsa_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bsa_state_t;
endpackage

// File: rtl/byte_serial_adder_if.sv
// Operand/result handshake bundle for byte_serial_adder.
// Optional build macro: BSA_SUB_EN (adds in_sub).
interface byte_serial_adder_if
    import bsa_pkg::*;
#(
    parameter int NBYTES = 4
);
    localparam int W = NBYTES * BYTE_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef BSA_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin,
`ifdef BSA_SUB_EN
        output in_sub,
`endif
        output out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin,
`ifdef BSA_SUB_EN
        input  in_sub,
`endif
        input  out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/byte_serial_adder_ripple_8.sv
// 8-bit ripple-carry adder shared by the byte-serial datapath.
module ripple_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic cy;

    always_comb begin
        cy  = cin;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ cy;
            cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        cout = cy;
    end
endmodule

// File: rtl/byte_serial_adder.sv
// Multi-byte adder: one ripple_8 reused LSB-first, one byte per clock.
// Optional build macro: BSA_SUB_EN (A-B mode selected by in_sub).
//
// state | meaning
// IDLE  | ready for operands
// RUN   | adding one byte per cycle, carry held between bytes
// DONE  | result held until out_ready
module byte_serial_adder
    import bsa_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    byte_serial_adder_if.slave  bus
);
    localparam int W    = NBYTES * BYTE_W;
    localparam int IDXW = $clog2(NBYTES);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]        state;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic [W-1:0]      sum_reg;
    logic              carry;
    logic              cout_reg;
    logic [IDXW-1:0]   idx;
    logic [BYTE_W-1:0] add_b;
    logic [BYTE_W-1:0] add_s;
    logic              add_co;
    logic              seed;

`ifdef BSA_SUB_EN
    logic sub_reg;
    // Subtract is A + ~B + 1, so the carry seed is forced high.
    assign add_b = sub_reg ? ~b_reg[BYTE_W-1:0] : b_reg[BYTE_W-1:0];
    assign seed  = bus.in_sub | bus.in_cin;
`else
    assign add_b = b_reg[BYTE_W-1:0];
    assign seed  = bus.in_cin;
`endif

    ripple_8 u_add (
        .a    (a_reg[BYTE_W-1:0]),
        .b    (add_b),
        .cin  (carry),
        .sum  (add_s),
        .cout (add_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            idx      <= '0;
`ifdef BSA_SUB_EN
            sub_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg   <= bus.in_a;
                        b_reg   <= bus.in_b;
                        carry   <= seed;
                        idx     <= '0;
`ifdef BSA_SUB_EN
                        sub_reg <= bus.in_sub;
`endif
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Sum bytes enter at the top so byte 0 lands at the bottom after NBYTES shifts.
                    sum_reg <= {add_s, sum_reg[W-1:BYTE_W]};
                    carry   <= add_co;
                    a_reg   <= a_reg >> BYTE_W;
                    b_reg   <= b_reg >> BYTE_W;
                    idx     <= idx + 1'b1;
                    if (idx == IDXW'(NBYTES - 1)) begin
                        cout_reg <= add_co;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_sum   = sum_reg;
    assign bus.out_cout  = cout_reg;
endmodule

// File: tb/tb_byte_serial_adder.sv
// Randomized and directed checks of byte_serial_adder against an arithmetic reference.
module tb_byte_serial_adder;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;
    // one IDLE cycle + NBYTES RUN cycles + one DONE cycle between accepts
    localparam int PERIOD = NBYTES + 2;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    byte_serial_adder_if #(.NBYTES(NBYTES)) bus ();

    byte_serial_adder #(.NBYTES(NBYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_cin = cin;
`ifdef BSA_SUB_EN
        bus.in_sub = sub;
`endif
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input bit keep, output int acc);
        drive(a, b, cin, sub);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 20 && !bus.in_ready; k++) step();
        chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
        step();
        acc = cyc;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [W:0] exp, input int hold);
        int k;
        k = 0;
        while (!bus.out_valid && k < 20) begin
            step();
            k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'(NBYTES));
        chk({tag, "_sum"}, 64'(bus.out_sum), 64'(exp[W-1:0]));
        chk({tag, "_cout"}, 64'(bus.out_cout), 64'(exp[W]));
        chk({tag, "_rdy_done"}, 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            drive($urandom, $urandom, 1'b1, 1'b0);
            step();
            chk({tag, "_hold_vld"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "_hold_sum"}, 64'(bus.out_sum), 64'(exp[W-1:0]));
            chk({tag, "_hold_cout"}, 64'(bus.out_cout), 64'(exp[W]));
            chk({tag, "_hold_rdy"}, 64'(bus.in_ready), 64'd0);
        end
        if (hold > 0) bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk({tag, "_vld_clr"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_rdy_set"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
        int acc;
        send(a, b, cin, sub, 1'b0, acc);
        collect(tag, model(a, b, cin, sub), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        int           acc;
        int           prev_acc;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive('0, '0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
        chk("rst_out_cout", 64'(bus.out_cout), 64'd0);
        rst = 1'b0;

        // result left in out_sum so the mid-RUN reset has something to clear
        run_op("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("ripple_all", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_op("pre_rst", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);

        send($urandom, $urandom, 1'b1, 1'b0, 1'b0, acc);
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrun_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrun_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrun_rst_out_sum", 64'(bus.out_sum), 64'd0);
        chk("midrun_rst_out_cout", 64'(bus.out_cout), 64'd0);
        step();
        rst = 1'b0;
        run_op("post_rst", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
`ifdef BSA_SUB_EN
            sub = 1'($urandom_range(0, 1));
`else
            sub = 1'b0;
`endif
            run_op("rand", a, b, cin, sub);
        end

        bus.out_ready = 1'b0;
        a = $urandom;
        b = $urandom;
        send(a, b, 1'b0, 1'b0, 1'b0, acc);
        collect("backpressure", model(a, b, 1'b0, 1'b0), 5);

        prev_acc = 0;
        for (int i = 0; i < 3; i++) begin
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            send(a, b, cin, 1'b0, 1'b1, acc);
            if (i > 0) chk("b2b_spacing", 64'(acc - prev_acc), 64'(PERIOD));
            prev_acc = acc;
            collect("b2b", model(a, b, cin, 1'b0), 0);
        end
        bus.in_valid = 1'b0;
        step();
        chk("b2b_idle_after", 64'(bus.in_ready), 64'd1);

`ifdef BSA_SUB_EN
        run_op("sub_5_7", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        run_op("sub_7_5", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
        chk("sub_model_5_7", 64'(model(32'd5, 32'd7, 1'b0, 1'b1)), 64'h0_FFFF_FFFE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
